// File: rtl/alu_src_arbiter.sv
// Round-robin arbiter sharing the ALU operand path between three sources, with a
// one-entry valid/ready output register. Optional lock support: ALU_SRC_ARB_LOCK_EN.
module alu_src_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
`ifdef ALU_SRC_ARB_LOCK_EN
  input  logic [2:0]       lock,
`endif
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [2:0]       gnt,
  output logic [1:0]       choice,
  output logic [WIDTH-1:0] res,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    SRC0  = 2'b00,
    SRC1  = 2'b01,
    SRC2  = 2'b10,
    EMPTY = 2'b11
  } src_t;

  src_t             choice_q;
  logic [WIDTH-1:0] res_q;
  logic             valid_q;
  logic [1:0]       last_q;

  logic             can_accept;
  logic             found;
  logic [1:0]       gidx;
  logic [1:0]       cand;
  logic [1:0]       nlast;
  logic [WIDTH-1:0] sel_data;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Search last+1, last+2, last; first requester wins.
  always_comb begin
    can_accept = !valid_q || out_ready;
    found      = 1'b0;
    gidx       = last_q;
    cand       = last_q;
    gnt        = '0;
    if (rst_n && can_accept) begin
      for (int unsigned k = 1; k <= 3; k++) begin
        cand = wrap3({1'b0, last_q} + 3'(k));
        if (!found && req[cand]) begin
          found = 1'b1;
          gidx  = cand;
        end
      end
    end
    if (found) begin
      gnt[gidx] = 1'b1;
    end
  end

  always_comb begin
    sel_data = in2;
    case (gidx)
      2'd0:    sel_data = in0;
      2'd1:    sel_data = in1;
      default: sel_data = in2;
    endcase
  end

  // A locked grant parks the pointer one step behind, so the same source is searched first.
  always_comb begin
    nlast = gidx;
`ifdef ALU_SRC_ARB_LOCK_EN
    if (lock[gidx]) begin
      nlast = (gidx == 2'd0) ? 2'd2 : gidx - 2'd1;
    end
`else
    nlast = gidx;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q    <= '0;
      choice_q <= EMPTY;
      valid_q  <= 1'b0;
      last_q   <= 2'd2;
    end else if (found) begin
      res_q    <= sel_data;
      choice_q <= src_t'(gidx);
      valid_q  <= 1'b1;
      last_q   <= nlast;
    end else if (valid_q && out_ready) begin
      choice_q <= EMPTY;
      valid_q  <= 1'b0;
    end
  end

  assign res       = res_q;
  assign choice    = choice_q;
  assign out_valid = valid_q;

endmodule
